// File: rtl/dsp_data_bank.sv
// -----------------------------------------------------------------------------
// dsp_data_bank
// DEPTH-word data bank answering the DSP core's Bank I read port and Bank II
// read/write port, plus a host load port whose words are queued in a small
// FIFO and written into the array on cycles where the DSP is not writing.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   read_addr_1/_data_1 Bank I read, data registered (latency 1)
//   read_addr_2/_data_2 Bank II read, data registered (latency 1)
//   write_addr_2/_data_2/_en_2  Bank II DSP write, always wins the array
//   host_valid/_ready   host word handshake (enqueue when both high)
//   host_addr/_data     host target address and word
//   host_count          number of queued host entries
//   host_idle           queue empty
// -----------------------------------------------------------------------------
module dsp_data_bank #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             read_addr_1,
    output logic [WORD_W-1:0]             read_data_1,
    input  logic [ADDR_W-1:0]             read_addr_2,
    output logic [WORD_W-1:0]             read_data_2,
    input  logic [ADDR_W-1:0]             write_addr_2,
    input  logic [WORD_W-1:0]             write_data_2,
    input  logic                          write_en_2,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [WORD_W-1:0]             host_data,
    output logic [$clog2(FIFO_DEPTH):0]   host_count,
    output logic                          host_idle
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Read-path priority: a DSP write to the same address wins, then the
    // word being committed from the host queue, then the stored array word.
    function automatic logic [WORD_W-1:0] read_select(
        input logic [ADDR_W-1:0] rd_addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [WORD_W-1:0] wr_data,
        input logic              cm_en,
        input logic [ADDR_W-1:0] cm_addr,
        input logic [WORD_W-1:0] cm_data,
        input logic [WORD_W-1:0] arr_word
    );
        logic [WORD_W-1:0] sel;
        if (wr_en && (rd_addr == wr_addr)) begin
            sel = wr_data;
        end else if (cm_en && (rd_addr == cm_addr)) begin
            sel = cm_data;
        end else begin
            sel = arr_word;
        end
        return sel;
    endfunction

    logic [WORD_W-1:0] r_mem       [DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [WORD_W-1:0] r_fifo_data [FIFO_DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_read_data_1;
    logic [WORD_W-1:0] r_read_data_2;

    logic              w_empty;
    logic              w_full;
    logic              w_commit;
    logic              w_enq;
    logic [ADDR_W-1:0] w_head_addr;
    logic [WORD_W-1:0] w_head_data;
    logic [WORD_W-1:0] w_rd1_next;
    logic [WORD_W-1:0] w_rd2_next;

    // Queue status, commit/enqueue decisions and read-port selection.
    always_comb begin
        w_empty     = (r_count == {CNT_W{1'b0}});
        w_full      = (r_count == FULL_CNT);
        w_head_addr = r_fifo_addr[r_rd_ptr];
        w_head_data = r_fifo_data[r_rd_ptr];
        // The head commits in every slot the DSP leaves free.
        w_commit    = !write_en_2 && !w_empty;
        // A full queue still accepts a word when the head leaves this cycle;
        // host_valid is deliberately not part of this term.
        host_ready  = !w_full || w_commit;
        w_enq       = host_valid && host_ready;
        w_rd1_next  = read_select(read_addr_1, write_en_2, write_addr_2, write_data_2,
                                  w_commit, w_head_addr, w_head_data, r_mem[read_addr_1]);
        w_rd2_next  = read_select(read_addr_2, write_en_2, write_addr_2, write_data_2,
                                  w_commit, w_head_addr, w_head_data, r_mem[read_addr_2]);
    end

    // Storage array: DSP write has priority, otherwise the queue head commits.
    // Contents are intentionally not affected by reset.
    always_ff @(posedge clk) begin
        if (write_en_2) begin
            r_mem[write_addr_2] <= write_data_2;
        end else if (w_commit) begin
            r_mem[w_head_addr] <= w_head_data;
        end
    end

    // Host queue payload storage; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_addr[r_wr_ptr] <= host_addr;
            r_fifo_data[r_wr_ptr] <= host_data;
        end
    end

    // Queue pointers and occupancy; reset discards queued entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_commit) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read data for both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data_1 <= {WORD_W{1'b0}};
            r_read_data_2 <= {WORD_W{1'b0}};
        end else begin
            r_read_data_1 <= w_rd1_next;
            r_read_data_2 <= w_rd2_next;
        end
    end

    assign read_data_1 = r_read_data_1;
    assign read_data_2 = r_read_data_2;
    assign host_count  = r_count;
    assign host_idle   = (r_count == {CNT_W{1'b0}});

endmodule

// File: doc/dsp_data_bank.md
Name: dsp_data_bank

Overview:
- Responder end of the DSP data-memory interface: a DEPTH-word storage bank serving the core's Bank I read port and Bank II read/write port.
- Adds a host load port (valid/ready) through which the receiver front end deposits sample words; these are queued in a small FIFO and committed in idle write slots.
- Sits beside the DSP core at top level; one instance drives both read_data_1 and read_data_2.

Parameters:
- WORD_W, 16, data word width; equals `REG_WORD_LEN.
- ADDR_W, 10, address width; equals `SRAM_ADDR_LEN; DEPTH = 2**ADDR_W.
- FIFO_DEPTH, 4, host write queue entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_addr_1  in  ADDR_W  DSP Bank I read address.
- read_data_1  out  WORD_W  Bank I read data, registered.
- read_addr_2  in  ADDR_W  DSP Bank II read address.
- read_data_2  out  WORD_W  Bank II read data, registered.
- write_addr_2  in  ADDR_W  DSP Bank II write address.
- write_data_2  in  WORD_W  DSP Bank II write data.
- write_en_2  in  1  DSP Bank II write strobe, one word per cycle.
- host_valid  in  1  host word offered.
- host_ready  out  1  FIFO can accept a word.
- host_addr  in  ADDR_W  host target address.
- host_data  in  WORD_W  host word.
- host_count  out  $clog2(FIFO_DEPTH)+1  queued host entries.
- host_idle  out  1  FIFO empty and no commit in progress.

Behaviour:
- Reset (rst=0, async): read_data_1=0, read_data_2=0, FIFO pointers and host_count=0, host_ready=1, host_idle=1. Array contents are not cleared.
- Reads:
  - Sampled at the clock edge; data appears on read_data_x one cycle later (latency 1).
  - Both ports read independently every cycle.
  - There is no read enable; outputs update every cycle.
- DSP write: when write_en_2=1, the array at write_addr_2 takes write_data_2 on the edge. DSP writes always have priority.
- Read/write collision: a read (either port) of write_addr_2 in the same cycle as a DSP write returns write_data_2 (write-first bypass).
- Host enqueue: occurs when host_valid and host_ready are both 1 at an edge.
  - host_ready = (host_count < FIFO_DEPTH), or a commit is happening this cycle while full (simultaneous enq+deq allowed when full).
  - host_ready depends only on registered state plus write_en_2; no combinational path from host_valid.
- Host commit:
  - On any cycle with write_en_2=0 and FIFO non-empty, the head entry is written to the array and popped.
  - At most one commit per cycle.
  - When write_en_2=1, commit stalls; the head is held unchanged.
- Commit bypass: a read of the address being host-committed in that cycle returns the committed data. Entries still queued are NOT forwarded; reads return old array content.
- Same-address ordering: a DSP write at cycle N followed by a host commit to the same address at N+1 leaves the host data. The order is strictly by commit cycle.
- host_count:
  - +1 on enqueue only, -1 on commit only, unchanged on both or neither.
  - Never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- host_idle = (host_count == 0).
- Enqueue when full without a simultaneous commit is impossible (host_ready=0); a word presented then is held by the host, not dropped.
- Reset mid-operation: queued host entries are discarded. A write already committed before the reset edge remains in the array.
- Out-of-range addresses cannot occur (full decode of ADDR_W).

Test Plan:
- Reset then DSP writes 0x1234 @0x005, next cycle read_addr_1=0x005 -> read_data_1=0x1234 one cycle after the read address.
- Same-cycle write_en_2=1, write_addr_2=0x010, write_data_2=0xBEEF, read_addr_2=0x010 -> read_data_2=0xBEEF next cycle (bypass).
- Host pushes 4 words (0xA0..0xA3 @0x100..0x103) while write_en_2 held 1 -> host_count=4, host_ready=0, no array change; drop write_en_2 -> one commit per cycle, host_count 3,2,1,0, host_idle=1, reads return 0xA0..0xA3.
- FIFO full and write_en_2=0, host_valid=1 -> host_ready=1, enqueue and commit in the same cycle, host_count stays 4.
- DSP writes 0x1111 @0x020 at cycle N, queued host entry 0x2222 @0x020 commits at N+1 -> final read returns 0x2222; a read of 0x020 at N+1 with a different address committing returns 0x1111.
- Assert rst=0 with 3 entries queued -> host_count=0, read_data_1/2=0 immediately (async); previously committed words still readable after release.
